// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: pipeline WB write, MDU
// issue/result handshake, merged write port and status outputs.
interface wb_write_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    logic                      pipe_we;
    logic [4:0]                pipe_waddr;
    logic [31:0]               pipe_wdata;
    logic                      mdu_issue;
    logic [4:0]                mdu_issue_dst;
    logic                      mdu_valid;
    logic                      mdu_ready;
    logic [4:0]                mdu_waddr;
    logic [31:0]               mdu_wdata;
    logic                      rf_we;
    logic [4:0]                rf_waddr;
    logic [31:0]               rf_wdata;
    logic [31:0]               busy_mask;
    logic                      pipe_stall;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      err;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  mdu_issue, mdu_issue_dst,
        input  mdu_valid, mdu_waddr, mdu_wdata,
        output mdu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output busy_mask, pipe_stall, fifo_count, err
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output mdu_issue, mdu_issue_dst,
        output mdu_valid, mdu_waddr, mdu_wdata,
        input  mdu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  busy_mask, pipe_stall, fifo_count, err
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Sole driver of the register-file write port: pipeline WB writes always win,
// MUL/DIV results queue in a FIFO, with a busy scoreboard and starvation stall.
module wb_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               reset,
    wb_write_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   busy;
    logic [31:0]   busy_next;
    logic [SW-1:0] starve_cnt;
    logic          stall_q;
    logic          err_q;
    logic          err_next;
    logic          pipe_hit;
    logic          empty;
    logic          full;
    logic          ready;
    logic          push;
    logic          pop;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign pipe_hit  = bus.pipe_we && (bus.pipe_waddr != '0);
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign ready     = !full && !reset;
    assign push      = bus.mdu_valid && ready;
    assign pop       = !pipe_hit && !empty;
    assign head_addr = q_addr[rd_ptr];
    assign head_data = q_data[rd_ptr];

    assign bus.mdu_ready  = ready;
    assign bus.busy_mask  = busy;
    assign bus.pipe_stall = stall_q;
    assign bus.fifo_count = count;
    assign bus.err        = err_q;

    // Write-port mux; a popped entry addressed to $0 still drains but writes nothing.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (!reset) begin
            if (pipe_hit) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.pipe_waddr;
                bus.rf_wdata = bus.pipe_wdata;
            end else if (!empty && head_addr != '0) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = head_addr;
                bus.rf_wdata = head_data;
            end
        end
    end

    // Clear from the pop is applied before the set from a same-cycle issue.
    always_comb begin
        busy_next = busy;
        if (pop && head_addr != '0)
            busy_next[head_addr] = 1'b0;
        if (bus.mdu_issue && bus.mdu_issue_dst != '0)
            busy_next[bus.mdu_issue_dst] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        err_next = err_q;
        if (bus.mdu_issue && bus.mdu_issue_dst != '0 && busy[bus.mdu_issue_dst])
            err_next = 1'b1;
        if (pipe_hit && (busy[bus.pipe_waddr] || stall_q))
            err_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.mdu_waddr;
            q_data[wr_ptr] <= bus.mdu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            busy   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            busy  <= busy_next;
            err_q <= err_next;
        end
    end

    // Nonempty FIFO without a pop implies the pipeline held the port this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            if (empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                starve_cnt <= '0;
                stall_q    <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed vector table, multi-cycle
// corner sequences and randomized traffic against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    wb_write_arbiter_if #(.DEPTH(DEPTH)) bus_if ();

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_busy;
    int          m_cnt;
    logic        m_stall;
    logic        m_err;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_busy  = '0;
        m_cnt   = 0;
        m_stall = 1'b0;
        m_err   = 1'b0;
    endfunction

    task automatic zero_inputs();
        bus_if.pipe_we       = 1'b0;
        bus_if.pipe_waddr    = '0;
        bus_if.pipe_wdata    = '0;
        bus_if.mdu_issue     = 1'b0;
        bus_if.mdu_issue_dst = '0;
        bus_if.mdu_valid     = 1'b0;
        bus_if.mdu_waddr     = '0;
        bus_if.mdu_wdata     = '0;
    endtask

    // Compare every output against the model a few ns after inputs change.
    task automatic settle();
        logic       hit;
        logic       e_we;
        logic [4:0] e_a;
        logic [31:0] e_d;
        #3;
        hit  = bus_if.pipe_we && bus_if.pipe_waddr != 5'd0;
        e_we = 1'b0;
        e_a  = '0;
        e_d  = '0;
        if (hit) begin
            e_we = 1'b1;
            e_a  = bus_if.pipe_waddr;
            e_d  = bus_if.pipe_wdata;
        end else if (mq.size() > 0 && mq[0].a != 5'd0) begin
            e_we = 1'b1;
            e_a  = mq[0].a;
            e_d  = mq[0].d;
        end
        chk("rf_we", 32'(bus_if.rf_we), 32'(e_we));
        if (e_we || mq.size() == 0) begin
            chk("rf_waddr", 32'(bus_if.rf_waddr), 32'(e_a));
            chk("rf_wdata", bus_if.rf_wdata, e_d);
        end
        chk("mdu_ready", 32'(bus_if.mdu_ready), 32'(mq.size() < DEPTH));
        chk("busy_mask", bus_if.busy_mask, m_busy);
        chk("fifo_count", 32'(bus_if.fifo_count), 32'(mq.size()));
        chk("pipe_stall", 32'(bus_if.pipe_stall), 32'(m_stall));
        chk("err", 32'(bus_if.err), 32'(m_err));
    endtask

    // Reference step: apply the clock-edge rules to the queue model.
    function automatic void m_step();
        logic        hit;
        logic        pop;
        logic        push;
        logic        stall_n;
        logic [31:0] nb;
        hit  = bus_if.pipe_we && bus_if.pipe_waddr != 5'd0;
        pop  = !hit && mq.size() > 0;
        push = bus_if.mdu_valid && mq.size() < DEPTH;
        if (bus_if.mdu_issue && bus_if.mdu_issue_dst != 5'd0 && m_busy[bus_if.mdu_issue_dst])
            m_err = 1'b1;
        if (hit && (m_busy[bus_if.pipe_waddr] || m_stall))
            m_err = 1'b1;
        nb = m_busy;
        if (pop && mq[0].a != 5'd0)
            nb[mq[0].a] = 1'b0;
        if (bus_if.mdu_issue && bus_if.mdu_issue_dst != 5'd0)
            nb[bus_if.mdu_issue_dst] = 1'b1;
        stall_n = 1'b0;
        if (mq.size() == 0 || pop) begin
            m_cnt = 0;
        end else if (m_cnt == LIMIT - 1) begin
            m_cnt   = 0;
            stall_n = 1'b1;
        end else begin
            m_cnt++;
        end
        if (pop)
            void'(mq.pop_front());
        if (push)
            mq.push_back({bus_if.mdu_waddr, bus_if.mdu_wdata});
        m_busy  = nb;
        m_stall = stall_n;
    endfunction

    task automatic clk_edge();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic drive_pipe(logic we, logic [4:0] a, logic [31:0] d);
        bus_if.pipe_we    = we;
        bus_if.pipe_waddr = a;
        bus_if.pipe_wdata = d;
    endtask

    task automatic drive_mdu(logic v, logic [4:0] a, logic [31:0] d);
        bus_if.mdu_valid = v;
        bus_if.mdu_waddr = a;
        bus_if.mdu_wdata = d;
    endtask

    task automatic drive_issue(logic iss, logic [4:0] dst);
        bus_if.mdu_issue     = iss;
        bus_if.mdu_issue_dst = dst;
    endtask

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        iss;
        logic [4:0]  idst;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [31:0] ebusy;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vt[14];

    initial begin
        logic [4:0] got[$];
        int         idx;
        int         budget;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        zero_inputs();
        m_reset();

        vt[0]  = '{0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            32'h0,   0};
        vt[1]  = '{1, 8, 32'h1234,     0, 0, 0, 0, 0,            1, 8, 32'h1234,     32'h0,   0};
        vt[2]  = '{0, 0, 0,            1, 9, 0, 0, 0,            0, 0, 0,            32'h0,   0};
        vt[3]  = '{0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            32'h200, 0};
        vt[4]  = '{0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            32'h200, 0};
        vt[5]  = '{0, 0, 0,            0, 0, 1, 9, 32'hBEEF,     0, 0, 0,            32'h200, 0};
        vt[6]  = '{0, 0, 0,            0, 0, 0, 0, 0,            1, 9, 32'hBEEF,     32'h200, 1};
        vt[7]  = '{0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            32'h0,   0};
        vt[8]  = '{1, 0, 32'hFFFF,     0, 0, 0, 0, 0,            0, 0, 0,            32'h0,   0};
        vt[9]  = '{0, 0, 0,            1, 0, 0, 0, 0,            0, 0, 0,            32'h0,   0};
        vt[10] = '{0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            32'h0,   0};
        vt[11] = '{0, 0, 0,            0, 0, 1, 0, 32'h55,       0, 0, 0,            32'h0,   0};
        vt[12] = '{0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            32'h0,   1};
        vt[13] = '{0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            32'h0,   0};

        do_reset();

        // Directed table: pipe write, issue/result round trip, $0 handling.
        for (int i = 0; i < 14; i++) begin
            drive_pipe(vt[i].pw, vt[i].pa, vt[i].pd);
            drive_issue(vt[i].iss, vt[i].idst);
            drive_mdu(vt[i].mv, vt[i].ma, vt[i].md);
            settle();
            chk($sformatf("vec%0d_rf_we", i), 32'(bus_if.rf_we), 32'(vt[i].ewe));
            if (vt[i].ewe) begin
                chk($sformatf("vec%0d_rf_waddr", i), 32'(bus_if.rf_waddr), 32'(vt[i].ea));
                chk($sformatf("vec%0d_rf_wdata", i), bus_if.rf_wdata, vt[i].ed);
            end
            chk($sformatf("vec%0d_busy", i), bus_if.busy_mask, vt[i].ebusy);
            chk($sformatf("vec%0d_count", i), 32'(bus_if.fifo_count), 32'(vt[i].ecnt));
            clk_edge();
        end
        zero_inputs();

        // FIFO fills while pipeline holds the port; 5th result is held, then all drain in order.
        do_reset();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive_pipe(1'b1, 5'd1, 32'(c));
            drive_mdu(idx < 5, 5'(11 + idx), 32'hA000 + 32'(idx));
            settle();
            if (c == 4) begin
                chk("full_count", 32'(bus_if.fifo_count), 32'd4);
                chk("full_ready", 32'(bus_if.mdu_ready), 32'd0);
            end
            if (bus_if.mdu_valid && mq.size() < DEPTH)
                idx++;
            clk_edge();
        end
        drive_pipe(1'b0, 5'd0, 32'd0);
        budget = 0;
        while (got.size() < 5 && budget < 12) begin
            drive_mdu(idx < 5, 5'(11 + idx), 32'hA000 + 32'(idx));
            settle();
            if (bus_if.rf_we)
                got.push_back(bus_if.rf_waddr);
            if (bus_if.mdu_valid && mq.size() < DEPTH)
                idx++;
            clk_edge();
            budget++;
        end
        chk("drain_len", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("drain_order%0d", i), 32'(got[i]), 32'(11 + i));
        zero_inputs();

        // Starvation: 8 blocked cycles, stall on the 9th with the head popped.
        do_reset();
        drive_pipe(1'b1, 5'd1, 32'h1);
        drive_mdu(1'b1, 5'd7, 32'h77);
        settle();
        clk_edge();
        drive_mdu(1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            drive_pipe(1'b1, 5'd2, 32'(k));
            settle();
            chk("starve_no_stall", 32'(bus_if.pipe_stall), 32'd0);
            clk_edge();
        end
        drive_pipe(1'b0, 5'd0, 32'd0);
        settle();
        chk("starve_stall", 32'(bus_if.pipe_stall), 32'd1);
        chk("starve_pop_we", 32'(bus_if.rf_we), 32'd1);
        chk("starve_pop_addr", 32'(bus_if.rf_waddr), 32'd7);
        clk_edge();
        settle();
        chk("starve_stall_one", 32'(bus_if.pipe_stall), 32'd0);
        chk("starve_empty", 32'(bus_if.fifo_count), 32'd0);
        clk_edge();

        // Double issue to $10 sets sticky err.
        do_reset();
        drive_issue(1'b1, 5'd10);
        settle();
        clk_edge();
        settle();
        chk("dbl_issue_err_before", 32'(bus_if.err), 32'd0);
        clk_edge();
        drive_issue(1'b0, 5'd0);
        settle();
        chk("dbl_issue_err", 32'(bus_if.err), 32'd1);
        chk("dbl_issue_busy", bus_if.busy_mask, 32'h400);
        clk_edge();
        repeat (3) begin
            settle();
            clk_edge();
        end
        settle();
        chk("err_sticky", 32'(bus_if.err), 32'd1);
        clk_edge();

        // WAW: pipeline write to busy $10 passes through but flags err.
        do_reset();
        drive_issue(1'b1, 5'd10);
        settle();
        clk_edge();
        drive_issue(1'b0, 5'd0);
        drive_pipe(1'b1, 5'd10, 32'hCAFE);
        settle();
        chk("waw_we", 32'(bus_if.rf_we), 32'd1);
        chk("waw_wdata", bus_if.rf_wdata, 32'hCAFE);
        chk("waw_err_before", 32'(bus_if.err), 32'd0);
        clk_edge();
        drive_pipe(1'b0, 5'd0, 32'd0);
        settle();
        chk("waw_err", 32'(bus_if.err), 32'd1);
        clk_edge();

        // Mid-cycle reset with 3 queued entries and busy=0x600.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive_pipe(1'b1, 5'd1, 32'(c));
            drive_issue(c < 2, (c == 0) ? 5'd9 : 5'd10);
            drive_mdu(1'b1, 5'(20 + c), 32'hD0 + 32'(c));
            settle();
            clk_edge();
        end
        drive_issue(1'b0, 5'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        settle();
        chk("pre_reset_count", 32'(bus_if.fifo_count), 32'd3);
        chk("pre_reset_busy", bus_if.busy_mask, 32'h600);
        reset = 1'b1;
        #1;
        chk("rst_count", 32'(bus_if.fifo_count), 32'd0);
        chk("rst_busy", bus_if.busy_mask, 32'd0);
        chk("rst_rf_we", 32'(bus_if.rf_we), 32'd0);
        chk("rst_ready", 32'(bus_if.mdu_ready), 32'd0);
        chk("rst_err", 32'(bus_if.err), 32'd0);
        do_reset();

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                drive_pipe($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom);
                drive_issue($urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)));
                drive_mdu($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
                settle();
                clk_edge();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
